psram_arbiter: RTL and testbench

- Shares one PsramController between two requesters, e.g. port 0 = CPU and port 1 = video/DMA.
- Round-robin arbitration with a req/ack handshake per port.
- Sequences each access as a one-cycle read/write pulse to the controller, then waits for busy to clear.
- Includes a watchdog that flags a hung controller. Sits between the system logic and PsramController, in the clk domain.

---
 rtl/psram_arb_pkg.sv | 16 +
 rtl/psram_rr_pick.sv | 19 +
 rtl/psram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_psram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared types and constants for the PSRAM arbiter
package psram_arb_pkg;

    localparam int ADDR_W_DEF  = 22;
    localparam int DATA_W_DEF  = 16;
    localparam int GRANT_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GUARD,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/psram_rr_pick.sv
// rtl/psram_rr_pick.sv - combinational two-way round-robin picker
module psram_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        if (req_i == 2'b11) begin
            winner_o = ~last_i;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port round-robin arbiter in front of a PsramController
// Per-port grant counters are built only when PSRAM_ARB_STATS_EN is defined.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic                   be0,
    input  logic                   be1,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [DATA_W-1:0]      wdata0,
    input  logic [DATA_W-1:0]      wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [DATA_W-1:0]      rdata0,
    output logic [DATA_W-1:0]      rdata1,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_byte_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_din,
    input  logic [DATA_W-1:0]      mem_dout,
    input  logic                   mem_busy,
    output logic                   owner,
    output logic                   timeout_err,
    output logic [GRANT_CNT_W-1:0] grant_cnt0,
    output logic [GRANT_CNT_W-1:0] grant_cnt1
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              tout_q, tout_d;
    logic              pick_valid, pick_winner, sel_we;
    logic              finish;

    psram_rr_pick u_pick (
        .req_i    ({req1, req0}),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    assign sel_we = pick_winner ? we1 : we0;
    assign finish = (state_q == WAIT) && (state_d == DONE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        tout_d      = tout_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // busy high also covers controller power-up init
                if (pick_valid && !mem_busy) begin
                    owner_d     = pick_winner;
                    we_d        = sel_we;
                    mem_write_d = sel_we;
                    mem_read_d  = ~sel_we;
                    mem_be_d    = pick_winner ? be1 : be0;
                    mem_addr_d  = pick_winner ? addr1 : addr0;
                    mem_din_d   = pick_winner ? wdata1 : wdata0;
                    state_d     = CMD;
                end
            end
            CMD: begin
                cnt_d   = '0;
                state_d = GUARD;
            end
            GUARD: begin
                // the controller raises busy one cycle after the command
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = mem_dout;
                        else         rdata0_d = mem_dout;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            ack0_d = ~owner_q;
            ack1_d = owner_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            tout_q      <= tout_d;
        end
    end

`ifdef PSRAM_ARB_STATS_EN
    logic [GRANT_CNT_W-1:0] gcnt0_q, gcnt1_q;

    // counts land on the same edge as the ack so they are visible with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (finish) begin
            if (!owner_q && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + GRANT_CNT_W'(1);
            if (owner_q && (gcnt1_q != '1))  gcnt1_q <= gcnt1_q + GRANT_CNT_W'(1);
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byte_write = mem_be_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign owner          = owner_q;
    assign timeout_err    = tout_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - self-checking bench for psram_arbiter
module tb_psram_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int TO = 64;
`ifdef PSRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic          be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, we0, we1, be0, be1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic mem_read, mem_write, mem_byte_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic mem_busy;
    logic owner, timeout_err;
    logic [15:0] grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
        .owner(owner), .timeout_err(timeout_err),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller model: busy rises the cycle after a command and stays high busy_len cycles
    int            busy_len = 1;
    bit            busy_hold = 1'b1;
    logic [DW-1:0] dout_val = '0;
    int            busy_left = 0;
    bit            ctl_cmd = 1'b0;

    always @(negedge clk) ctl_cmd = mem_read || mem_write;

    initial begin
        mem_busy = 1'b1;
        mem_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_cmd) busy_left = busy_len;
            mem_busy = busy_hold || (busy_left > 0);
            if (busy_left > 0) busy_left--;
            mem_dout = dout_val;
        end
    end

    // Reference model: transaction-level prediction of grant, timing and data
    bit            fl = 1'b0;
    int            fl_port, fl_ack, m_w, m_L;
    bit            fl_rd, fl_to;
    logic [DW-1:0] fl_data;
    logic          m_last = 1'b1, m_owner = 1'b0, m_be = 1'b0, m_to = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0, m_rd0 = '0, m_rd1 = '0;
    int            m_cnt0 = 0, m_cnt1 = 0;
    logic [1:0]    p_req = '0;
    logic          p_busy = 1'b1, p_we0, p_we1, p_be0, p_be1, prev_to = 1'b0;
    logic [AW-1:0] p_addr0, p_addr1;
    logic [DW-1:0] p_wd0, p_wd1;
    bit            e_ack0, e_ack1;
    int            glog[$];
    int            cmd_cyc_last = -1, obs_ack = -1, obs_to = -1, n_ack = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ctrl", 64'({ack0, ack1, mem_read, mem_write, mem_byte_write, owner, timeout_err}), 64'd0);
            chk("rst_addr", 64'(mem_addr), 64'd0);
            chk("rst_din", 64'(mem_din), 64'd0);
            chk("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
            chk("rst_gcnt", 64'({grant_cnt0, grant_cnt1}), 64'd0);
            fl = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_be = 1'b0; m_to = 1'b0;
            m_addr = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0; m_cnt0 = 0; m_cnt1 = 0;
            obs_to = -1;
        end else begin
            if (mem_read || mem_write) begin
                chk("cmd_while_active", 64'(fl), 64'd0);
                chk("cmd_both_pulses", 64'(mem_read && mem_write), 64'd0);
                chk("cmd_while_busy", 64'(p_busy), 64'd0);
                chk("cmd_without_req", 64'(p_req != 2'b00), 64'd1);
                m_w     = (p_req == 2'b11) ? int'(!m_last) : int'(p_req[1]);
                m_owner = m_w[0];
                m_addr  = m_w[0] ? p_addr1 : p_addr0;
                m_din   = m_w[0] ? p_wd1 : p_wd0;
                m_be    = m_w[0] ? p_be1 : p_be0;
                chk("cmd_write", 64'(mem_write), 64'(m_w[0] ? p_we1 : p_we0));
                m_L     = busy_len;
                fl      = 1'b1;
                fl_port = m_w;
                fl_rd   = !(m_w[0] ? p_we1 : p_we0);
                fl_data = dout_val;
                fl_to   = (m_L >= TO);
                if (fl_to)        fl_ack = cyc + TO + 1;
                else if (m_L <= 1) fl_ack = cyc + 3;
                else              fl_ack = cyc + m_L + 2;
                glog.push_back(m_w);
                cmd_cyc_last = cyc;
            end
            e_ack0 = fl && (fl_port == 0) && (cyc == fl_ack);
            e_ack1 = fl && (fl_port == 1) && (cyc == fl_ack);
            if (fl && (cyc == fl_ack)) begin
                if (fl_rd && !fl_to) begin
                    if (fl_port == 0) m_rd0 = fl_data;
                    else              m_rd1 = fl_data;
                end
                if (fl_to) m_to = 1'b1;
                if (fl_port == 0 && m_cnt0 < 65535) m_cnt0++;
                if (fl_port == 1 && m_cnt1 < 65535) m_cnt1++;
                m_last = fl_port[0];
                fl     = 1'b0;
            end
            if (ack0 || ack1) begin
                obs_ack = cyc;
                n_ack++;
            end
            if (timeout_err && !prev_to) obs_to = cyc;
            chk("ack0", 64'(ack0), 64'(e_ack0));
            chk("ack1", 64'(ack1), 64'(e_ack1));
            chk("rdata0", 64'(rdata0), 64'(m_rd0));
            chk("rdata1", 64'(rdata1), 64'(m_rd1));
            chk("timeout_err", 64'(timeout_err), 64'(m_to));
            chk("owner", 64'(owner), 64'(m_owner));
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_din", 64'(mem_din), 64'(m_din));
            chk("mem_byte_write", 64'(mem_byte_write), 64'(m_be));
            chk("grant_cnt0", 64'(grant_cnt0), STATS ? 64'(m_cnt0) : 64'd0);
            chk("grant_cnt1", 64'(grant_cnt1), STATS ? 64'(m_cnt1) : 64'd0);
        end
        prev_to = timeout_err;
        p_req   = {req1, req0};
        p_busy  = mem_busy;
        p_we0 = we0; p_we1 = we1; p_be0 = be0; p_be1 = be1;
        p_addr0 = addr0; p_addr1 = addr1; p_wd0 = wdata0; p_wd1 = wdata1;
    end

    // Requester side
    txn_t q0[$];
    txn_t q1[$];
    int   last_pres[2];

    function automatic txn_t mk(input logic we, input logic be, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.be = be; t.addr = a; t.wdata = d;
        return t;
    endfunction

    task automatic wait_ack(input int p);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? ack0 : ack1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_wait_p%0d: no ack after %0d cycles, required within 400", p, n);
        end
    endtask

    task automatic drive(input int p);
        txn_t t;
        bit more;
        more = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        while (more) begin
            if (p == 0) begin
                t = q0.pop_front();
                req0 = 1'b1; we0 = t.we; be0 = t.be; addr0 = t.addr; wdata0 = t.wdata;
            end else begin
                t = q1.pop_front();
                req1 = 1'b1; we1 = t.we; be1 = t.be; addr1 = t.addr; wdata1 = t.wdata;
            end
            last_pres[p] = cyc;
            wait_ack(p);
            @(posedge clk);
            #1;
            more = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int hold_rel, n0, nw;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; be0 = 1'b0; be1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // power-up busy: no command until the controller releases busy
        q0.push_back(mk(1'b1, 1'b0, 22'h000010, 16'hA5A5));
        fork
            drive(0);
            begin
                repeat (100) @(negedge clk);
                busy_hold = 1'b0;
                hold_rel  = cyc;
            end
        join
        chk("t1_addr", 64'(mem_addr), 64'h10);
        chk("t1_din", 64'(mem_din), 64'hA5A5);
        chk("t1_grants", 64'(glog.size()), 64'd1);
        chk("t1_after_busy", 64'(cmd_cyc_last > hold_rel), 64'd1);

        // minimum latency with busy already low in the first WAIT cycle
        idle(3);
        busy_len = 1;
        dout_val = 16'h1111;
        q0.push_back(mk(1'b0, 1'b0, 22'h000020, 16'h0));
        drive(0);
        chk("lat_req_to_ack", 64'(obs_ack - last_pres[0]), 64'd4);
        chk("lat_rdata0", 64'(rdata0), 64'h1111);

        // simultaneous requests, then strict alternation
        do_reset();
        glog.delete();
        busy_len = 8;
        dout_val = 16'h5A00;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 1'b0, AW'(22'h100 + i), 16'h0));
            q1.push_back(mk(1'b0, 1'b1, AW'(22'h200 + i), 16'h0));
        end
        fork
            drive(0);
            drive(1);
        join
        chk("t2_grants", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("t2_order", 64'(glog[i]), 64'(i % 2));

        // read on port 1 leaves port 0 data alone
        idle(2);
        busy_len = 3;
        dout_val = 16'h1234;
        q0.push_back(mk(1'b0, 1'b0, 22'h000040, 16'h0));
        drive(0);
        dout_val = 16'h3C5A;
        q1.push_back(mk(1'b0, 1'b1, 22'h0FFFFF, 16'h0));
        drive(1);
        chk("t3_rdata1", 64'(rdata1), 64'h3C5A);
        chk("t3_rdata0", 64'(rdata0), 64'h1234);

        // hung controller trips the watchdog, access still acked
        idle(2);
        busy_len = 200;
        q0.push_back(mk(1'b1, 1'b0, 22'h000100, 16'hBEEF));
        drive(0);
        chk("t4_rise_after_cmd", 64'(obs_to - (cmd_cyc_last + 1)), 64'd64);
        chk("t4_ack_with_rise", 64'(obs_ack), 64'(obs_to));
        busy_len = 2;
        dout_val = 16'h7777;
        q1.push_back(mk(1'b0, 1'b0, 22'h000200, 16'h0));
        drive(1);
        chk("t4_next_rdata1", 64'(rdata1), 64'h7777);
        chk("t4_sticky", 64'(timeout_err), 64'd1);

        // reset while waiting on busy
        idle(2);
        busy_len = 30;
        req0 = 1'b1; we0 = 1'b1; be0 = 1'b0; addr0 = 22'h000300; wdata0 = 16'hCAFE;
        nw = 0;
        while (!mem_write && nw < 200) begin
            @(negedge clk);
            nw++;
        end
        chk("t5_cmd_seen", 64'(mem_write), 64'd1);
        idle(5);
        n0 = n_ack;
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        chk("t5_async_ctrl", 64'({ack0, owner, timeout_err, mem_write}), 64'd0);
        chk("t5_async_addr", 64'(mem_addr), 64'd0);
        idle(2);
        reset = 1'b0;
        idle(40);
        chk("t5_no_ack", 64'(n_ack - n0), 64'd0);
        busy_len = 3;
        q0.push_back(mk(1'b1, 1'b0, 22'h000304, 16'h0F0F));
        drive(0);
        chk("t5_fresh_ack", 64'(n_ack - n0), 64'd1);
        chk("t5_fresh_addr", 64'(mem_addr), 64'h304);

        // grant statistics
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 1'b0, AW'(22'h400 + i), 16'h1));
        for (int i = 0; i < 5; i++) q1.push_back(mk(1'b1, 1'b1, AW'(22'h500 + i), 16'h2));
        fork
            drive(0);
            drive(1);
        join
        idle(2);
        chk("t6_gcnt0", 64'(grant_cnt0), STATS ? 64'd3 : 64'd0);
        chk("t6_gcnt1", 64'(grant_cnt1), STATS ? 64'd5 : 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule
